// File: rtl/mac_accum_requant_if.sv
// Operand/control sideband and result handshake bundle for mac_accum_requant.
// The DUT uses the slave modport; the producer/consumer side uses master.
interface mac_accum_requant_if #(
    parameter int PROD_WIDTH = 23,
    parameter int BIAS_WIDTH = 16,
    parameter int OUT_WIDTH  = 16
);
    logic                  in_valid;
    logic                  in_first;
    logic                  in_last;
    logic [BIAS_WIDTH-1:0] bias;
    logic [PROD_WIDTH-1:0] prod;
    logic                  out_valid;
    logic                  out_ready;
    logic [OUT_WIDTH-1:0]  out_data;

    modport master (
        output in_valid, in_first, in_last, bias, prod, out_ready,
        input  out_valid, out_data
    );

    modport slave (
        input  in_valid, in_first, in_last, bias, prod, out_ready,
        output out_valid, out_data
    );
endinterface

// File: rtl/mac_accum_requant.sv
// Dense-layer accumulator: sums multiplier products per neuron, adds bias, rounds,
// shifts and saturates to the activation width. Optional fused ReLU: MAC_ACCUM_RELU_EN.
module mac_accum_requant #(
    parameter int PROD_WIDTH  = 23,
    parameter int ACC_WIDTH   = 32,
    parameter int BIAS_WIDTH  = 16,
    parameter int OUT_WIDTH   = 16,
    parameter int OUT_SHIFT   = 10,
    parameter int MUL_LATENCY = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ce,
    mac_accum_requant_if.slave bus,
    output logic               err_seq,
    output logic               err_ovr
);
    localparam int RW = ACC_WIDTH + 1 - OUT_SHIFT;
    localparam logic signed [ACC_WIDTH:0] HALF = (ACC_WIDTH + 1)'(1) << (OUT_SHIFT - 1);

    typedef enum logic {IDLE, RUN} state_t;

    logic [MUL_LATENCY-1:0] dlValid_q;
    logic [MUL_LATENCY-1:0] dlFirst_q;
    logic [MUL_LATENCY-1:0] dlLast_q;
    logic [BIAS_WIDTH-1:0]  dlBias_q [MUL_LATENCY];

    state_t                 state_q, state_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [ACC_WIDTH-1:0]   finReg_q, finReg_d;
    logic                   finPend_q, finPend_d;
    logic                   errSeq_q, errSeq_d;
    logic                   errOvr_q, errOvr_d;
    logic                   outValid_q, outValid_d;
    logic [OUT_WIDTH-1:0]   outData_q, outData_d;

    logic                   dValid, dFirst, dLast;
    logic [ACC_WIDTH-1:0]   biasExt, prodExt;
    logic signed [ACC_WIDTH:0] rounded;
    logic signed [RW-1:0]   shifted;
    logic [RW-OUT_WIDTH:0]  upperBits;
    logic [OUT_WIDTH-1:0]   satData, reqData;
    logic                   outLoad;

    // Sideband delay line so control lines up with the multiplier output.
    always_ff @(posedge clk) begin
        if (reset) begin
            dlValid_q <= '0;
            dlFirst_q <= '0;
            dlLast_q  <= '0;
            for (int i = 0; i < MUL_LATENCY; i++) dlBias_q[i] <= '0;
        end else if (ce) begin
            dlValid_q[0] <= bus.in_valid;
            dlFirst_q[0] <= bus.in_first;
            dlLast_q[0]  <= bus.in_last;
            dlBias_q[0]  <= bus.bias;
            for (int i = 1; i < MUL_LATENCY; i++) begin
                dlValid_q[i] <= dlValid_q[i-1];
                dlFirst_q[i] <= dlFirst_q[i-1];
                dlLast_q[i]  <= dlLast_q[i-1];
                dlBias_q[i]  <= dlBias_q[i-1];
            end
        end
    end

    assign dValid  = dlValid_q[MUL_LATENCY-1];
    assign dFirst  = dlFirst_q[MUL_LATENCY-1];
    assign dLast   = dlLast_q[MUL_LATENCY-1];
    assign biasExt = ACC_WIDTH'(signed'(dlBias_q[MUL_LATENCY-1]));
    assign prodExt = ACC_WIDTH'(signed'(bus.prod));

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        finReg_d  = finReg_q;
        finPend_d = 1'b0;
        errSeq_d  = errSeq_q;
        if (dValid) begin
            if (dFirst) begin
                acc_d   = biasExt + prodExt;
                state_d = dLast ? IDLE : RUN;
                if (state_q == RUN) errSeq_d = 1'b1;
            end else if (state_q == IDLE) begin
                errSeq_d = 1'b1;
            end else begin
                acc_d = acc_q + prodExt;
                if (dLast) state_d = IDLE;
            end
            if (dLast && (dFirst || state_q == RUN)) begin
                finReg_d  = acc_d;
                finPend_d = 1'b1;
            end
        end
    end

    // Round half up, then saturate whenever the bits above the output sign disagree.
    assign rounded   = signed'({finReg_q[ACC_WIDTH-1], finReg_q}) + HALF;
    assign shifted   = RW'(rounded >>> OUT_SHIFT);
    assign upperBits = shifted[RW-1:OUT_WIDTH-1];

    always_comb begin
        satData = shifted[OUT_WIDTH-1:0];
        if (!((&upperBits) || !(|upperBits))) begin
            satData = shifted[RW-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                    : {1'b0, {(OUT_WIDTH-1){1'b1}}};
        end
`ifdef MAC_ACCUM_RELU_EN
        reqData = satData[OUT_WIDTH-1] ? '0 : satData;
`else
        reqData = satData;
`endif
    end

    assign outLoad = finPend_q && (!outValid_q || bus.out_ready);

    always_comb begin
        outValid_d = outValid_q;
        outData_d  = outData_q;
        errOvr_d   = errOvr_q;
        if (outLoad) begin
            outValid_d = 1'b1;
            outData_d  = reqData;
        end else begin
            if (outValid_q && bus.out_ready) outValid_d = 1'b0;
            if (finPend_q) errOvr_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            finReg_q   <= '0;
            finPend_q  <= 1'b0;
            errSeq_q   <= 1'b0;
            errOvr_q   <= 1'b0;
            outValid_q <= 1'b0;
            outData_q  <= '0;
        end else if (ce) begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            finReg_q   <= finReg_d;
            finPend_q  <= finPend_d;
            errSeq_q   <= errSeq_d;
            errOvr_q   <= errOvr_d;
            outValid_q <= outValid_d;
            outData_q  <= outData_d;
        end
    end

    assign bus.out_valid = outValid_q;
    assign bus.out_data  = outData_q;
    assign err_seq       = errSeq_q;
    assign err_ovr       = errOvr_q;
endmodule

// File: tb/tb_mac_accum_requant.sv
// Self-checking bench for mac_accum_requant: term-level reference model with a
// per-cycle compare process, directed literal checks and a randomized phase.
module tb_mac_accum_requant;
    localparam int PW  = 23;
    localparam int BW  = 16;
    localparam int OW  = 16;
    localparam int SH  = 10;

    logic clk = 1'b0;
    logic reset;
    logic ce;
    logic errSeq, errOvr;

    mac_accum_requant_if #(.PROD_WIDTH(PW), .BIAS_WIDTH(BW), .OUT_WIDTH(OW)) bus();

    mac_accum_requant dut (
        .clk     (clk),
        .reset   (reset),
        .ce      (ce),
        .bus     (bus),
        .err_seq (errSeq),
        .err_ovr (errOvr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int due;
        bit first;
        bit last;
        int bias;
        int prod;
    } term_t;

    typedef struct {
        int due;
        int value;
    } res_t;

    term_t termQ[$];
    res_t  resQ[$];

    int vecCount  = 0;
    int missCount = 0;
    bit chkEn     = 1'b0;

    int ceCount   = 0;
    bit inNeuron  = 1'b0;
    int sum       = 0;
    bit expValid  = 1'b0;
    int expData   = 0;
    bit expSeq    = 1'b0;
    bit expOvr    = 1'b0;

    int pipe0 = 0;
    int pipe1 = 0;

    bit aRst, aCe, aValid, aFirst, aLast, aRdy;
    int aBias, aProd;

    function automatic int requant(input int s);
        longint r;
        r = (longint'(s) + longint'(2 ** (SH - 1))) >>> SH;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
`ifdef MAC_ACCUM_RELU_EN
        if (r < 0) r = 0;
`endif
        return int'(r);
    endfunction

    function automatic int randProd();
        return int'($urandom_range(0, 8388607)) - 4194304;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        vecCount++;
        if (got != exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Reference model: terms are seen by the accumulator two ce edges after they
    // are presented; a finished neuron reaches the output register one ce edge later.
    task automatic modelEdge();
        term_t t;
        res_t  r;
        if (aRst) begin
            termQ.delete();
            resQ.delete();
            ceCount  = 0;
            inNeuron = 1'b0;
            sum      = 0;
            expValid = 1'b0;
            expData  = 0;
            expSeq   = 1'b0;
            expOvr   = 1'b0;
        end else if (aCe) begin
            ceCount++;
            if (resQ.size() > 0 && resQ[0].due == ceCount) begin
                r = resQ.pop_front();
                if (!expValid || aRdy) begin
                    expValid = 1'b1;
                    expData  = r.value;
                end else begin
                    expOvr = 1'b1;
                end
            end else if (expValid && aRdy) begin
                expValid = 1'b0;
            end
            if (termQ.size() > 0 && termQ[0].due == ceCount) begin
                t = termQ.pop_front();
                if (t.first) begin
                    if (inNeuron) expSeq = 1'b1;
                    sum = t.bias + t.prod;
                    inNeuron = 1'b1;
                end else if (!inNeuron) begin
                    expSeq = 1'b1;
                end else begin
                    sum = sum + t.prod;
                end
                if (inNeuron && t.last) begin
                    r.due   = ceCount + 1;
                    r.value = requant(sum);
                    resQ.push_back(r);
                    inNeuron = 1'b0;
                end
            end
            if (aValid) begin
                t.due   = ceCount + 2;
                t.first = aFirst;
                t.last  = aLast;
                t.bias  = aBias;
                t.prod  = aProd;
                termQ.push_back(t);
            end
        end
    endtask

    // One clock of stimulus; prod is fed through a two-stage emulated multiplier.
    task automatic applyStimulus(input bit rst, input bit c, input bit v, input bit f,
                                 input bit l, input int b, input int p, input bit rdy);
        @(negedge clk);
        reset         = rst;
        ce            = c;
        bus.in_valid  = v;
        bus.in_first  = f;
        bus.in_last   = l;
        bus.bias      = BW'(b);
        bus.out_ready = rdy;
        bus.prod      = PW'(pipe1);
        aRst = rst; aCe = c; aValid = v; aFirst = f; aLast = l;
        aBias = b; aProd = p; aRdy = rdy;
        @(posedge clk);
        modelEdge();
        if (c) begin
            pipe1 = pipe0;
            pipe0 = p;
        end
    endtask

    task automatic idle(input bit rdy);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, randProd(), rdy);
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic checkOutput(input string name, input bit v, input int d);
        #1;
        check({name, "_valid"}, int'(bus.out_valid), int'(v));
        check({name, "_data"}, int'($signed(bus.out_data)), d);
        check({name, "_model_valid"}, int'(expValid), int'(v));
        check({name, "_model_data"}, expData, d);
    endtask

    task automatic checkFlags(input string name, input bit s, input bit o);
        #1;
        check({name, "_err_seq"}, int'(errSeq), int'(s));
        check({name, "_err_ovr"}, int'(errOvr), int'(o));
    endtask

    task automatic waitValid(input string name, input int maxCyc);
        int n = 0;
        #1;
        while (!bus.out_valid && n < maxCyc) begin
            idle(1'b0);
            #1;
            n++;
        end
        if (!bus.out_valid) begin
            vecCount++;
            missCount++;
            $display("[TB] FAIL %s_timeout: got out_valid 0 after %0d cycles, expected 1", name, n);
        end
    endtask

    always @(negedge clk) begin
        if (chkEn) begin
            check("cyc_out_valid", int'(bus.out_valid), int'(expValid));
            check("cyc_out_data", int'($signed(bus.out_data)), expData);
            check("cyc_err_seq", int'(errSeq), int'(expSeq));
            check("cyc_err_ovr", int'(errOvr), int'(expOvr));
        end
    end

    initial begin
        int remain;
        bit rst, c, v, f, l, rdy;
        int b, p;
        reset = 1'b1; ce = 1'b0;
        bus.in_valid = 1'b0; bus.in_first = 1'b0; bus.in_last = 1'b0;
        bus.bias = '0; bus.prod = '0; bus.out_ready = 1'b0;

        doReset();
        chkEn = 1'b1;
        checkOutput("reset", 1'b0, 0);
        checkFlags("reset", 1'b0, 1'b0);

        $display("[TB] basic neuron");
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 512, 1024, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 2048, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 0, -512, 1'b0);
        idle(1'b0);
        idle(1'b0);
        checkOutput("basic_early", 1'b0, 0);
        idle(1'b0);
        checkOutput("basic", 1'b1, 3);
        checkFlags("basic", 1'b0, 1'b0);
        idle(1'b1);

        $display("[TB] rounding and sign");
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 0, -1024, 1'b0);
        waitValid("round_neg", 20);
`ifdef MAC_ACCUM_RELU_EN
        checkOutput("round_neg", 1'b1, 0);
`else
        checkOutput("round_neg", 1'b1, -1);
`endif
        idle(1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 0, -512, 1'b0);
        waitValid("round_half", 20);
        checkOutput("round_half", 1'b1, 0);
        idle(1'b1);

        $display("[TB] saturation");
        for (int i = 0; i < 32; i++)
            applyStimulus(1'b0, 1'b1, 1'b1, i == 0, i == 31, 0, 4194303, 1'b0);
        waitValid("sat_pos", 20);
        checkOutput("sat_pos", 1'b1, 32767);
        idle(1'b1);
        for (int i = 0; i < 32; i++)
            applyStimulus(1'b0, 1'b1, 1'b1, i == 0, i == 31, 0, -4194304, 1'b0);
        waitValid("sat_neg", 20);
`ifdef MAC_ACCUM_RELU_EN
        checkOutput("sat_neg", 1'b1, 0);
`else
        checkOutput("sat_neg", 1'b1, -32768);
`endif
        idle(1'b1);

        $display("[TB] back-to-back");
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 0, 3072, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 0, 5120, 1'b1);
        idle(1'b1);
        idle(1'b1);
        checkOutput("b2b_a", 1'b1, 3);
        idle(1'b1);
        checkOutput("b2b_b", 1'b1, 5);
        idle(1'b1);
        checkOutput("b2b_done", 1'b0, 5);
        checkFlags("b2b", 1'b0, 1'b0);

        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 0, 3072, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 0, 5120, 1'b0);
        idle(1'b0);
        idle(1'b0);
        checkOutput("ovr_a", 1'b1, 3);
        idle(1'b0);
        idle(1'b0);
        checkOutput("ovr_hold", 1'b1, 3);
        checkFlags("ovr", 1'b0, 1'b1);
        idle(1'b1);
        doReset();

        $display("[TB] protocol errors");
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 777, 1'b0);
        idle(1'b0);
        idle(1'b0);
        idle(1'b0);
        checkFlags("stray", 1'b1, 1'b0);
        checkOutput("stray", 1'b0, 0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 9999, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1234, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 2048, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 0, 1024, 1'b0);
        waitValid("restart", 20);
        checkOutput("restart", 1'b1, 3);
        idle(1'b1);
        doReset();

        $display("[TB] ce toggling");
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 512, 1024, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, randProd(), 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 2048, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, randProd(), 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 0, -512, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, randProd(), 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, randProd(), 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, randProd(), 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, randProd(), 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, randProd(), 1'b0);
        checkOutput("ce_early", 1'b0, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, randProd(), 1'b0);
        checkOutput("ce_result", 1'b1, 3);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, randProd(), 1'b1);
        checkOutput("ce_frozen", 1'b1, 3);
        idle(1'b1);

        $display("[TB] reset after last");
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 512, 1024, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 2048, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 0, -512, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        for (int i = 0; i < 5; i++) idle(1'b0);
        checkOutput("rst_mid", 1'b0, 0);
        checkFlags("rst_mid", 1'b0, 1'b0);

        $display("[TB] randomized phase");
        doReset();
        remain = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            rst = ($urandom_range(0, 399) == 0);
            c   = ($urandom_range(0, 9) < 8);
            rdy = $urandom_range(0, 1) != 0;
            v   = ($urandom_range(0, 9) < 7);
            f   = 1'b0;
            l   = 1'b0;
            if (v) begin
                if (remain == 0) begin
                    if ($urandom_range(0, 19) == 0) begin
                        l = $urandom_range(0, 1) != 0;
                    end else begin
                        remain = int'($urandom_range(1, 8));
                        f = 1'b1;
                    end
                end else if ($urandom_range(0, 29) == 0) begin
                    remain = int'($urandom_range(1, 8));
                    f = 1'b1;
                end
                if (remain > 0) l = (remain == 1);
            end
            p = ($urandom_range(0, 1) != 0) ? randProd() : int'($urandom_range(0, 40000)) - 20000;
            b = int'($urandom_range(0, 65535)) - 32768;
            applyStimulus(rst, c, v, f, l, b, p, rdy);
            if (rst) remain = 0;
            else if (c && v && remain > 0) remain--;
        end
        idle(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end
endmodule
